// File: rtl/display_mode_ctrl.sv
// Frame-synchronous display mode controller: arbitrates grant/alarm/clear events
// into a pattern_select code, changing mode only on vsync rising edges.
module display_mode_ctrl #(
   parameter int unsigned GRANT_FRAMES = 120,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vs_in,
   input  logic       grant_pulse,
   input  logic       alarm_pulse,
   input  logic       alarm_clear,
   output logic [1:0] pattern_select,
   output logic       alarm_active,
   output logic       frame_tick
);

   typedef enum logic [1:0] {IDLE, GRANT, ALARM} state_t;

   localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] fcnt, fcnt_n;
   logic             blink_on, blink_n;
   logic             vs_d;
   logic             alarm_pend, grant_pend, clear_pend;
   logic             alarm_take, grant_take, clear_take;
   logic [1:0]       pat_n;

   always_comb begin
      state_n    = state;
      fcnt_n     = fcnt;
      blink_n    = blink_on;
      alarm_take = 1'b0;
      grant_take = 1'b0;
      clear_take = 1'b0;
      if (frame_tick) begin
         // clear_pend is either acted on (ALARM) or discarded at every tick
         clear_take = 1'b1;
         if (alarm_pend) begin
            state_n    = ALARM;
            fcnt_n     = '0;
            blink_n    = 1'b1;
            alarm_take = 1'b1;
            grant_take = 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (grant_pend) begin
                     state_n    = GRANT;
                     fcnt_n     = '0;
                     grant_take = 1'b1;
                  end
               end
               GRANT: begin
                  if (grant_pend) begin
                     fcnt_n     = '0;
                     grant_take = 1'b1;
                  end else if (fcnt == GRANT_LAST) begin
                     state_n = IDLE;
                  end else begin
                     fcnt_n = fcnt + CNT_W'(1);
                  end
               end
               ALARM: begin
                  grant_take = 1'b1;
                  if (clear_pend) begin
                     state_n = IDLE;
                  end else if (fcnt == BLINK_LAST) begin
                     blink_n = ~blink_on;
                     fcnt_n  = '0;
                  end else begin
                     fcnt_n = fcnt + CNT_W'(1);
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      pat_n = 2'd0;
      case (state_n)
         GRANT:   pat_n = 2'd1;
         ALARM:   pat_n = blink_n ? 2'd2 : 2'd0;
         default: pat_n = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_d           <= 1'b0;
         frame_tick     <= 1'b0;
         state          <= IDLE;
         fcnt           <= '0;
         blink_on       <= 1'b0;
         alarm_pend     <= 1'b0;
         grant_pend     <= 1'b0;
         clear_pend     <= 1'b0;
         pattern_select <= 2'd0;
         alarm_active   <= 1'b0;
      end else begin
         vs_d           <= vs_in;
         frame_tick     <= vs_in & ~vs_d;
         state          <= state_n;
         fcnt           <= fcnt_n;
         blink_on       <= blink_n;
         // A pulse landing on the consuming tick survives to the next tick
         alarm_pend     <= (alarm_pend & ~alarm_take) | alarm_pulse;
         grant_pend     <= (grant_pend & ~grant_take) | grant_pulse;
         clear_pend     <= (clear_pend & ~clear_take) | (alarm_clear & ~alarm_pulse);
         pattern_select <= pat_n;
         alarm_active   <= (state_n == ALARM);
      end
   end

endmodule
